// File: rtl/morse_key_sequencer_if.sv
// Key inputs and command/status outputs of the Morse key sequencer.
// Handshake: there is no valid/ready pair here. Keys are raw levels with no
// timing relation to clk; every *_cmd and ovf_err is a single-cycle pulse that
// the separator must accept in the cycle it is high.
interface morse_key_sequencer_if;
  logic       Dot;
  logic       Dash;
  logic       Space;
  logic       EndSeq;
  logic       Clear;
  logic       dot_cmd;
  logic       dash_cmd;
  logic       endseq_cmd;
  logic       space_cmd;
  logic       clear_cmd;
  logic       dot_buzzer;
  logic       dash_buzzer;
  logic [2:0] sym_count;
  logic       busy;
  logic       ovf_err;

  modport slave (
    input  Dot, Dash, Space, EndSeq, Clear,
    output dot_cmd, dash_cmd, endseq_cmd, space_cmd, clear_cmd,
    output dot_buzzer, dash_buzzer, sym_count, busy, ovf_err
  );

  modport master (
    output Dot, Dash, Space, EndSeq, Clear,
    input  dot_cmd, dash_cmd, endseq_cmd, space_cmd, clear_cmd,
    input  dot_buzzer, dash_buzzer, sym_count, busy, ovf_err
  );
endinterface

// File: rtl/morse_key_sequencer.sv
// Morse key front end: synchronizes and debounces five keys, arbitrates
// events, holds one pending event while a tone plays, and issues registered
// single-cycle commands to the separator together with buzzer timing.
module morse_key_sequencer #(
  parameter int DEBOUNCE  = 4,
  parameter int DOT_TONE  = 8,
  parameter int DASH_TONE = 24,
  parameter int GAP       = 8,
  parameter int MAX_SYMS  = 5
) (
  input  logic                  clk,
  input  logic                  Reset,
  morse_key_sequencer_if.slave  bus,
  output logic [1:0]            dbg_state_o
);
  localparam int NK   = 5;
  localparam int DBW  = $clog2(DEBOUNCE) + 1;
  localparam int TMAX = (DASH_TONE > DOT_TONE) ? ((DASH_TONE > GAP) ? DASH_TONE : GAP)
                                               : ((DOT_TONE > GAP) ? DOT_TONE : GAP);
  localparam int TW   = $clog2(TMAX) + 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE - 1);

  // Numeric value doubles as priority: a larger code beats a smaller one.
  typedef enum logic [2:0] {
    EV_NONE = 3'd0, EV_DOT = 3'd1, EV_DASH = 3'd2,
    EV_SPACE = 3'd3, EV_END = 3'd4, EV_CLR = 3'd5
  } ev_e;

  // ST_SPACE is the second cycle of endseq-then-space.
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TONE = 2'd1, ST_GAP = 2'd2, ST_SPACE = 2'd3} state_e;

  logic [NK-1:0]           keys_raw;
  logic [NK-1:0]           sync1_q, sync2_q;
  logic [NK-1:0]           pressed_q, pressed_d;
  logic [NK-1:0][DBW-1:0]  db_cnt_q, db_cnt_d;
  logic [NK-1:0]           press_evt;
  ev_e                     new_ev;

  state_e          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            tone_dash_q, tone_dash_d;
  ev_e             pend_q, pend_d;
  ev_e             serve;
  logic [2:0]      sym_q, sym_d;
  logic            dot_q, dot_d, dash_q, dash_d, end_q, end_d;
  logic            space_q, space_d, clr_q, clr_d, ovf_q, ovf_d;

  // Bit order matches event priority, lowest first.
  assign keys_raw = {bus.Clear, bus.EndSeq, bus.Space, bus.Dash, bus.Dot};

  // Two-flop synchronizer for every key.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
    end
  end

  // Debounce: count consecutive samples that disagree with the accepted level;
  // the DEBOUNCE-th one flips the level. A press event fires on that sample.
  always_comb begin
    pressed_d = pressed_q;
    db_cnt_d  = db_cnt_q;
    press_evt = '0;
    for (int k = 0; k < NK; k++) begin
      if (sync2_q[k] == pressed_q[k]) begin
        db_cnt_d[k] = '0;
      end else if (db_cnt_q[k] == DB_LAST) begin
        db_cnt_d[k]  = '0;
        pressed_d[k] = sync2_q[k];
        press_evt[k] = sync2_q[k];
      end else begin
        db_cnt_d[k] = db_cnt_q[k] + DBW'(1);
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      pressed_q <= '0;
      db_cnt_q  <= '0;
    end else begin
      pressed_q <= pressed_d;
      db_cnt_q  <= db_cnt_d;
    end
  end

  // Same-cycle arbitration: only the highest-priority event survives.
  always_comb begin
    new_ev = EV_NONE;
    if      (press_evt[4]) new_ev = EV_CLR;
    else if (press_evt[3]) new_ev = EV_END;
    else if (press_evt[2]) new_ev = EV_SPACE;
    else if (press_evt[1]) new_ev = EV_DASH;
    else if (press_evt[0]) new_ev = EV_DOT;
  end

  // Sequencer next state and registered command pulses.
  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    tone_dash_d = tone_dash_q;
    pend_d      = pend_q;
    sym_d       = sym_q;
    serve       = EV_NONE;
    dot_d       = 1'b0;
    dash_d      = 1'b0;
    end_d       = 1'b0;
    space_d     = 1'b0;
    clr_d       = 1'b0;
    ovf_d       = 1'b0;
    if (new_ev == EV_CLR) begin
      clr_d   = 1'b1;
      state_d = ST_IDLE;
      tmr_d   = '0;
      sym_d   = '0;
      pend_d  = EV_NONE;
    end else if (state_q == ST_IDLE) begin
      // A latched event is older, so it goes first; the new one takes its slot.
      if (pend_q != EV_NONE) begin
        serve  = pend_q;
        pend_d = new_ev;
      end else begin
        serve = new_ev;
      end
      case (serve)
        EV_DOT, EV_DASH: begin
          if (sym_q < 3'(MAX_SYMS)) begin
            dot_d       = (serve == EV_DOT);
            dash_d      = (serve == EV_DASH);
            sym_d       = sym_q + 3'd1;
            tone_dash_d = (serve == EV_DASH);
            tmr_d       = (serve == EV_DASH) ? TW'(DASH_TONE - 1) : TW'(DOT_TONE - 1);
            state_d     = ST_TONE;
          end else begin
            ovf_d = 1'b1;
          end
        end
        EV_END: begin
          if (sym_q != 3'd0) begin
            end_d = 1'b1;
            sym_d = '0;
          end
        end
        EV_SPACE: begin
          if (sym_q != 3'd0) begin
            end_d   = 1'b1;
            sym_d   = '0;
            state_d = ST_SPACE;
          end else begin
            space_d = 1'b1;
          end
        end
        default: ;
      endcase
    end else begin
      if (new_ev > pend_q) pend_d = new_ev;
      case (state_q)
        ST_TONE: begin
          if (tmr_q == '0) begin
            state_d = ST_GAP;
            tmr_d   = TW'(GAP - 1);
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end
        ST_GAP: begin
          if (tmr_q == '0) state_d = ST_IDLE;
          else             tmr_d   = tmr_q - TW'(1);
        end
        default: begin
          space_d = 1'b1;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer registers.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      tmr_q       <= '0;
      tone_dash_q <= 1'b0;
      pend_q      <= EV_NONE;
      sym_q       <= '0;
      dot_q       <= 1'b0;
      dash_q      <= 1'b0;
      end_q       <= 1'b0;
      space_q     <= 1'b0;
      clr_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      tone_dash_q <= tone_dash_d;
      pend_q      <= pend_d;
      sym_q       <= sym_d;
      dot_q       <= dot_d;
      dash_q      <= dash_d;
      end_q       <= end_d;
      space_q     <= space_d;
      clr_q       <= clr_d;
      ovf_q       <= ovf_d;
    end
  end

  // Buzzers follow the registered state, so Reset and Clear drop them at once.
  assign bus.dot_buzzer  = (state_q == ST_TONE) && !tone_dash_q;
  assign bus.dash_buzzer = (state_q == ST_TONE) &&  tone_dash_q;
  assign bus.busy        = (state_q == ST_TONE) || (state_q == ST_GAP);
  assign bus.sym_count   = sym_q;
  assign bus.dot_cmd     = dot_q;
  assign bus.dash_cmd    = dash_q;
  assign bus.endseq_cmd  = end_q;
  assign bus.space_cmd   = space_q;
  assign bus.clear_cmd   = clr_q;
  assign bus.ovf_err     = ovf_q;
  assign dbg_state_o     = state_q;
endmodule

// File: tb/tb_morse_key_sequencer.sv
// Directed bench for morse_key_sequencer: key presses with hand-computed
// command counts, tone lengths and cycle spacings.
module tb_morse_key_sequencer;
  localparam int DOT_TONE  = 8;
  localparam int DASH_TONE = 24;
  localparam int GAP       = 8;
  localparam int MAX_SYMS  = 5;
  localparam logic [4:0] K_DOT = 5'b00001, K_DASH = 5'b00010, K_SPACE = 5'b00100,
                         K_END = 5'b01000, K_CLR = 5'b10000;

  logic       clk = 1'b0;
  logic       Reset;
  logic [1:0] dbg_state;

  morse_key_sequencer_if bus();

  morse_key_sequencer #(
    .DEBOUNCE(4), .DOT_TONE(DOT_TONE), .DASH_TONE(DASH_TONE), .GAP(GAP), .MAX_SYMS(MAX_SYMS)
  ) dut (
    .clk(clk), .Reset(Reset), .bus(bus), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // monitor: pulse counts, tone lengths and event cycles sampled on the falling edge
  int cyc = 0;
  int n_dot = 0, n_dash = 0, n_end = 0, n_space = 0, n_clr = 0, n_ovf = 0, multi = 0;
  int end_cyc = 0, space_cyc = 0, dash_fall_cyc = 0;
  int dot_run = 0, dash_run = 0, last_dot_run = 0, last_dash_run = 0;
  logic       clr_dash_buzz = 1'b1, clr_busy = 1'b1;
  logic [2:0] clr_sym = 3'd7;

  always @(negedge clk) begin
    int hot;
    cyc++;
    n_dot   = n_dot   + int'(bus.dot_cmd);
    n_dash  = n_dash  + int'(bus.dash_cmd);
    n_end   = n_end   + int'(bus.endseq_cmd);
    n_space = n_space + int'(bus.space_cmd);
    n_clr   = n_clr   + int'(bus.clear_cmd);
    n_ovf   = n_ovf   + int'(bus.ovf_err);
    hot = int'(bus.dot_cmd) + int'(bus.dash_cmd) + int'(bus.endseq_cmd)
        + int'(bus.space_cmd) + int'(bus.clear_cmd);
    if (hot > 1) multi++;
    if (bus.endseq_cmd) end_cyc = cyc;
    if (bus.space_cmd) space_cyc = cyc;
    if (bus.clear_cmd) begin
      clr_dash_buzz = bus.dash_buzzer;
      clr_busy      = bus.busy;
      clr_sym       = bus.sym_count;
    end
    if (bus.dot_buzzer) dot_run++;
    else begin
      if (dot_run != 0) last_dot_run = dot_run;
      dot_run = 0;
    end
    if (bus.dash_buzzer) dash_run++;
    else begin
      if (dash_run != 0) begin
        last_dash_run = dash_run;
        dash_fall_cyc = cyc;
      end
      dash_run = 0;
    end
  end

  // scoreboard check
  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_keys(input logic [4:0] m);
    bus.Dot    = m[0];
    bus.Dash   = m[1];
    bus.Space  = m[2];
    bus.EndSeq = m[3];
    bus.Clear  = m[4];
  endtask

  task automatic press(input logic [4:0] m);
    set_keys(m);
    tick(8);
    set_keys(5'b0);
    tick(45);
  endtask

  int b_dot, b_dash, b_end, b_space, b_clr, b_ovf;
  task automatic snap();
    b_dot = n_dot; b_dash = n_dash; b_end = n_end;
    b_space = n_space; b_clr = n_clr; b_ovf = n_ovf;
  endtask

  initial begin
    // 1: reset with Dot held, then release reset
    Reset = 1'b0;
    set_keys(5'b0);
    tick(2);
    set_keys(K_DOT);
    tick(5);
    check_val("rst_outputs", 32'({bus.dot_cmd, bus.dash_cmd, bus.endseq_cmd, bus.space_cmd,
              bus.clear_cmd, bus.dot_buzzer, bus.dash_buzzer, bus.sym_count, bus.busy,
              bus.ovf_err}), 32'd0);
    check_val("rst_state", 32'(dbg_state), 32'd0);
    Reset = 1'b1;
    tick(10);
    set_keys(5'b0);
    tick(45);
    check_val("t1_dot_cmds", 32'(n_dot), 32'd1);
    check_val("t1_dot_tone", 32'(last_dot_run), 32'(DOT_TONE));
    check_val("t1_sym", 32'(bus.sym_count), 32'd1);
    check_val("t1_busy", 32'(bus.busy), 32'd0);

    // 2: Clear, then "S" and "O"
    snap();
    press(K_CLR);
    check_val("t2_clear", 32'(n_clr - b_clr), 32'd1);
    check_val("t2_sym_clr", 32'(bus.sym_count), 32'd0);
    snap();
    for (int i = 0; i < 3; i++) press(K_DOT);
    check_val("t2_s_dots", 32'(n_dot - b_dot), 32'd3);
    check_val("t2_s_sym", 32'(bus.sym_count), 32'd3);
    press(K_END);
    check_val("t2_s_end", 32'(n_end - b_end), 32'd1);
    check_val("t2_s_sym0", 32'(bus.sym_count), 32'd0);
    snap();
    for (int i = 0; i < 3; i++) press(K_DASH);
    check_val("t2_o_dashes", 32'(n_dash - b_dash), 32'd3);
    check_val("t2_dash_tone", 32'(last_dash_run), 32'(DASH_TONE));
    check_val("t2_o_sym", 32'(bus.sym_count), 32'd3);
    press(K_END);
    check_val("t2_o_end", 32'(n_end - b_end), 32'd1);
    check_val("t2_o_sym0", 32'(bus.sym_count), 32'd0);

    // 3: overflow on the sixth dot
    snap();
    for (int i = 0; i < MAX_SYMS; i++) press(K_DOT);
    check_val("t3_sym_full", 32'(bus.sym_count), 32'(MAX_SYMS));
    press(K_DOT);
    check_val("t3_ovf", 32'(n_ovf - b_ovf), 32'd1);
    check_val("t3_dots", 32'(n_dot - b_dot), 32'(MAX_SYMS));
    check_val("t3_sym_hold", 32'(bus.sym_count), 32'(MAX_SYMS));
    press(K_CLR);
    check_val("t3_sym_clr", 32'(bus.sym_count), 32'd0);

    // 4: Dot+Dash together, EndSeq during the dash tone
    snap();
    set_keys(K_DOT | K_DASH);
    tick(8);
    set_keys(5'b0);
    tick(4);
    set_keys(K_END);
    tick(8);
    set_keys(5'b0);
    tick(60);
    check_val("t4_dash", 32'(n_dash - b_dash), 32'd1);
    check_val("t4_no_dot", 32'(n_dot - b_dot), 32'd0);
    check_val("t4_end", 32'(n_end - b_end), 32'd1);
    check_val("t4_end_after_gap", 32'((end_cyc - dash_fall_cyc >= GAP + 1) &&
              (end_cyc - dash_fall_cyc <= GAP + 2)), 32'd1);
    check_val("t4_sym0", 32'(bus.sym_count), 32'd0);

    // 5: Dash Dash Space, then Space on an empty sequence
    snap();
    press(K_DASH);
    press(K_DASH);
    press(K_SPACE);
    check_val("t5_end", 32'(n_end - b_end), 32'd1);
    check_val("t5_space", 32'(n_space - b_space), 32'd1);
    check_val("t5_spacing", 32'(space_cyc - end_cyc), 32'd1);
    check_val("t5_sym0", 32'(bus.sym_count), 32'd0);
    snap();
    press(K_SPACE);
    check_val("t5_space_only", 32'(n_space - b_space), 32'd1);
    check_val("t5_no_end", 32'(n_end - b_end), 32'd0);

    // 6: Clear during a dash tone, then a short glitch
    snap();
    set_keys(K_DASH);
    for (int i = 0; i < 40 && !bus.dash_buzzer; i++) tick(1);
    check_val("t6_tone_start", 32'(bus.dash_buzzer), 32'd1);
    set_keys(5'b0);
    tick(5);
    set_keys(K_CLR);
    tick(8);
    set_keys(5'b0);
    tick(40);
    check_val("t6_dash", 32'(n_dash - b_dash), 32'd1);
    check_val("t6_clear", 32'(n_clr - b_clr), 32'd1);
    check_val("t6_buzz_at_clr", 32'(clr_dash_buzz), 32'd0);
    check_val("t6_busy_at_clr", 32'(clr_busy), 32'd0);
    check_val("t6_sym_at_clr", 32'(clr_sym), 32'd0);
    check_val("t6_tone_cut", 32'(last_dash_run < DASH_TONE), 32'd1);
    snap();
    set_keys(K_DOT);
    tick(2);
    set_keys(5'b0);
    tick(20);
    check_val("t6_glitch", 32'(n_dot - b_dot), 32'd0);
    check_val("t6_glitch_busy", 32'(bus.busy), 32'd0);

    check_val("one_hot_cmds", 32'(multi), 32'd0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
